mc_ctrl_fsm: RTL
================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1: rising-edge clock.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset.
REQ-004 Port op, input, 6: opcode from the instruction register; valid from DECODE onward.
REQ-005 Port mem_rdy, input, 1: memory completes the current read/write this cycle.
REQ-006 Ports pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, alusrca, regwrite, regdst: each output, 1, datapath strobe/select.
REQ-007 Ports pcsource, aluop, alusrcb: each output, 2, datapath select.
REQ-008 Port state, output, 4: current state encoding.
REQ-009 Port trap, output, 1: illegal opcode detected.
REQ-010 Port instr_done, output, 1: one-cycle pulse on the final cycle of each retired instruction.
REQ-011 Port instr_cnt, output, 16: count of retired instructions.

Function
REQ-012 The block SHALL be an FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ILLEGAL=12.
REQ-013 Encodings 13-15 SHALL go to FETCH on the next edge.
REQ-014 Transitions SHALL be:
- FETCH->DECODE when mem_rdy=1, else hold.
- DECODE by op: 100011/101011->MEMADR; 000000->EXEC; 000100->BRANCH; 000010->JUMP; 001000->ADDIEX; any other->ILLEGAL.
- MEMADR->MEMRD if op=100011, else MEMWR.
- MEMRD->MEMWB when mem_rdy=1, else hold.
- MEMWR->FETCH when mem_rdy=1, else hold.
- EXEC->ALUWB; ADDIEX->ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP->FETCH.
- ILLEGAL->ILLEGAL until reset.
REQ-015 Outputs SHALL be decoded from state; any signal not listed for a state is 0:
- FETCH: memread=1, alusrcb=01, irwrite=mem_rdy, pcwrite=mem_rdy.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: memread=1, iord=1.
- MEMWB: regwrite=1, memtoreg=1.
- MEMWR: memwrite=1, iord=1.
- EXEC: alusrca=1, aluop=10.
- ALUWB: regdst=1, regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcwritecond=1, pcsource=01.
- JUMP: pcwrite=1, pcsource=10.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- ILLEGAL: trap=1.
REQ-016 instr_done SHALL be 1 in MEMWB, ALUWB, ADDIWB, BRANCH and JUMP, and in MEMWR when mem_rdy=1.
REQ-017 instr_cnt SHALL increment by 1 at each clock edge where instr_done=1.
REQ-018 instr_cnt SHALL wrap from 16'hFFFF to 0.
REQ-019 Latency with mem_rdy held at 1 SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
REQ-020 Each cycle mem_rdy=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle of latency, with no write strobe asserted during the wait.
REQ-021 op SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.

Reset
REQ-022 rst_n=0 SHALL force state=FETCH and instr_cnt=0 immediately, without waiting for clk.
REQ-023 During reset, outputs SHALL show FETCH decode: memread=1, alusrcb=01, trap=0, instr_done=0, all write strobes 0 while mem_rdy=0.
REQ-024 Reset asserted mid-instruction (including in ILLEGAL) SHALL abandon the instruction without counting it.
REQ-025 After rst_n rises, the first active edge SHALL resume from FETCH.

Verification
REQ-026 op=100011, mem_rdy=1 -> state sequence 0,1,2,3,4,0; regwrite=memtoreg=1 in state 4; instr_cnt 0->1.
REQ-027 mem_rdy=0 for 3 cycles in FETCH, then 1 -> state stays 0 for 4 cycles; irwrite=pcwrite=0 for the first 3 cycles and 1 on the 4th; DECODE follows.
REQ-028 op=000100 -> states 0,1,8,0; pcwritecond=1, pcsource=01, aluop=01 in state 8; instr_done pulses once.
REQ-029 op=111111 -> state 12 held for 10 or more cycles; trap=1; all write strobes 0; instr_cnt unchanged.
REQ-030 sw with mem_rdy=0 in MEMWR, rst_n dropped mid-wait -> memwrite=0 and state=0 at once; instr_cnt=0.
REQ-031 instr_cnt preloaded to 16'hFFFF by running 65535 j instructions, then one more j -> instr_cnt=0.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
// Datapath control bundle between the multicycle controller and its datapath.
// The master (controller) drives strobes/selects; the slave supplies op and mem_rdy.
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic       mem_rdy;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       alusrca;
  logic       regwrite;
  logic       regdst;
  logic [1:0] pcsource;
  logic [1:0] aluop;
  logic [1:0] alusrcb;

  modport master (
    input  op, mem_rdy,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, alusrca, regwrite, regdst, pcsource, aluop, alusrcb
  );

  modport slave (
    output op, mem_rdy,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, alusrca, regwrite, regdst, pcsource, aluop, alusrcb
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU controller: lw 5, sw/R/addi 4, beq/j 3 cycles; every mem_rdy=0
// cycle in FETCH/MEMRD/MEMWR stalls one cycle with write strobes held low.
module mc_ctrl_fsm (
  input  logic          clk,
  input  logic          rst_n,
  mc_ctrl_fsm_if.master dp,
  output logic [3:0]    state,
  output logic          trap,
  output logic          instr_done,
  output logic [15:0]   instr_cnt
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      // Written every cycle so the counter's next value always derives from its current one.
      cnt_q   <= cnt_q + {15'd0, instr_done};
    end
  end

  always_comb begin
    state_d        = state_q;
    dp.pcwrite     = 1'b0;
    dp.pcwritecond = 1'b0;
    dp.iord        = 1'b0;
    dp.memread     = 1'b0;
    dp.memwrite    = 1'b0;
    dp.irwrite     = 1'b0;
    dp.memtoreg    = 1'b0;
    dp.alusrca     = 1'b0;
    dp.regwrite    = 1'b0;
    dp.regdst      = 1'b0;
    dp.pcsource    = 2'b00;
    dp.aluop       = 2'b00;
    dp.alusrcb     = 2'b00;
    trap           = 1'b0;
    instr_done     = 1'b0;

    case (state_q)
      FETCH: begin
        dp.memread = 1'b1;
        dp.alusrcb = 2'b01;
        dp.irwrite = dp.mem_rdy;
        dp.pcwrite = dp.mem_rdy;
        if (dp.mem_rdy) state_d = DECODE;
      end
      DECODE: begin
        dp.alusrcb = 2'b11;
        case (dp.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        dp.alusrca = 1'b1;
        dp.alusrcb = 2'b10;
        state_d    = (dp.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        dp.memread = 1'b1;
        dp.iord    = 1'b1;
        if (dp.mem_rdy) state_d = MEMWB;
      end
      MEMWB: begin
        dp.regwrite = 1'b1;
        dp.memtoreg = 1'b1;
        instr_done  = 1'b1;
        state_d     = FETCH;
      end
      MEMWR: begin
        dp.memwrite = 1'b1;
        dp.iord     = 1'b1;
        instr_done  = dp.mem_rdy;
        if (dp.mem_rdy) state_d = FETCH;
      end
      EXEC: begin
        dp.alusrca = 1'b1;
        dp.aluop   = 2'b10;
        state_d    = ALUWB;
      end
      ALUWB: begin
        dp.regdst   = 1'b1;
        dp.regwrite = 1'b1;
        instr_done  = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        dp.alusrca     = 1'b1;
        dp.aluop       = 2'b01;
        dp.pcwritecond = 1'b1;
        dp.pcsource    = 2'b01;
        instr_done     = 1'b1;
        state_d        = FETCH;
      end
      JUMP: begin
        dp.pcwrite  = 1'b1;
        dp.pcsource = 2'b10;
        instr_done  = 1'b1;
        state_d     = FETCH;
      end
      ADDIEX: begin
        dp.alusrca = 1'b1;
        dp.alusrcb = 2'b10;
        state_d    = ADDIWB;
      end
      ADDIWB: begin
        dp.regwrite = 1'b1;
        instr_done  = 1'b1;
        state_d     = FETCH;
      end
      ILLEGAL: begin
        trap    = 1'b1;
        state_d = ILLEGAL;
      end
      default: state_d = FETCH;
    endcase
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule
